// File: rtl/max_reduce_pkg.sv
// Shared definitions for the max-reduction scheduler: FSM encoding, default widths,
// engine latency and a small id-wrapping helper.
package max_reduce_pkg;

    localparam int DEF_W   = 32;
    localparam int DEF_CW  = 7;
    localparam int ENG_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    // Next requester index after id, wrapping to 0 past n-1.
    function automatic int next_id(input int id, input int n);
        return (id == n - 1) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  id,
    output logic            any
);

    int             idx;
    logic [IDW-1:0] idx_w;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt   = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx   = (int'(rr_ptr) + off) % NREQ;
            idx_w = idx[IDW-1:0];
            if (req[idx_w]) begin
                gnt        = '0;
                gnt[idx_w] = 1'b1;
                id         = idx_w;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/max_reduce_sched.sv
// Round-robin scheduler that time-shares one running-max engine between NREQ requesters
// and returns each job's maximum tagged with the owning requester id.
module max_reduce_sched
    import max_reduce_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int NREQ = 4,
    parameter int CW   = DEF_CW,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*CW-1:0] len,
    input  logic [NREQ*W-1:0] x,
    input  logic [NREQ-1:0]   x_valid,
    output logic [NREQ-1:0]   x_ready,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      res_y,
    output logic [IDW-1:0]    res_id,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              eng_clr,
    output logic              eng_en,
    output logic [W-1:0]      eng_x,
    input  logic [W-1:0]      eng_y,
    output logic              busy
);

    logic [W-1:0]  x_words   [NREQ];
    logic [CW-1:0] len_words [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign x_words[gi]   = x[gi*W +: W];
        assign len_words[gi] = len[gi*CW +: CW];
    end

    state_t          state_reg;
    logic [IDW-1:0]  id_reg;
    logic [IDW-1:0]  rr_ptr_reg;
    logic [CW-1:0]   len_reg;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic [NREQ-1:0] gnt_reg;
    logic [NREQ-1:0] x_ready_reg;
    logic            eng_clr_reg;
    logic            busy_reg;
    logic            res_valid_reg;
    logic [W-1:0]    res_y_reg;
    logic [IDW-1:0]  res_id_reg;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_id;
    logic            arb_any;
    logic            in_stream;
    logic            take;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .gnt    (arb_gnt),
        .id     (arb_id),
        .any    (arb_any)
    );

    assign in_stream = (state_reg == ST_STREAM);
    assign take      = in_stream & x_valid[id_reg];
    assign cnt_next  = cnt_reg + 1'b1;

    // Engine input is forced to zero outside STREAM so nothing leaks while idle or in reset.
    assign eng_en = take;
    assign eng_x  = in_stream ? x_words[id_reg] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            id_reg        <= '0;
            rr_ptr_reg    <= '0;
            len_reg       <= '0;
            gnt_reg       <= '0;
            x_ready_reg   <= '0;
            eng_clr_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            res_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arb_any) begin
                        id_reg      <= arb_id;
                        len_reg     <= len_words[arb_id];
                        gnt_reg     <= arb_gnt;
                        eng_clr_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    eng_clr_reg <= 1'b0;
                    if (len_reg == '0) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        x_ready_reg         <= '0;
                        x_ready_reg[id_reg] <= 1'b1;
                        state_reg           <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (take && cnt_next == len_reg) begin
                        x_ready_reg <= '0;
                        state_reg   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    res_valid_reg <= 1'b1;
                    state_reg     <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        gnt_reg       <= '0;
                        busy_reg      <= 1'b0;
                        rr_ptr_reg    <= IDW'(next_id(int'(id_reg), NREQ));
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (state_reg == ST_CLEAR) begin
            cnt_reg <= '0;
        end else if (take) begin
            cnt_reg <= cnt_next;
        end
    end

    // DRAIN covers the engine's one-cycle latency, so eng_y already holds the final maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_y_reg  <= '0;
            res_id_reg <= '0;
        end else if (state_reg == ST_DRAIN) begin
            res_y_reg  <= eng_y;
            res_id_reg <= id_reg;
        end
    end

    assign x_ready   = x_ready_reg;
    assign gnt       = gnt_reg;
    assign eng_clr   = eng_clr_reg;
    assign busy      = busy_reg;
    assign res_valid = res_valid_reg;
    assign res_y     = res_y_reg;
    assign res_id    = res_id_reg;

endmodule
